// File: rtl/cic_decimator_ser.sv
// cic_decimator_ser: parametrised 1-bit CIC decimator with input synchroniser and serial framer
module cic_decimator_ser #(
  parameter int ORDER = 3,
  parameter int LOG2_R = 6,
  parameter int OUT_W = 16,
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             data_i,
  output logic [OUT_W-1:0] sample_o,
  output logic             valid_o,
  output logic             data_o,
  output logic             frame_sync,
  output logic             overrun_o
);
  localparam int ACC_W = ORDER * LOG2_R + 2;
  localparam int BW = $clog2(OUT_W);
  typedef enum logic {IDLE, SHIFT} state_t;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [LOG2_R-1:0] r_cnt;
  logic [ACC_W-1:0] w_x;
  logic w_tick;
  logic signed [ACC_W-1:0] w_sh;
  state_t r_state, w_next;
  logic [BW-1:0] r_bcnt;
  logic [OUT_W-1:0] r_shreg;
  logic r_ovr, w_last, w_load, w_drop;
  assign w_x = {{(ACC_W-1){~r_sync[SYNC_STAGES-1]}}, 1'b1};
  assign w_tick = en && &r_cnt;
  always_ff @(posedge clk)
    if (rst) begin
      r_sync <= '0;
      r_cnt <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], data_i};
      if (en) r_cnt <= r_cnt + LOG2_R'(1);
    end
  for (genvar k = 0; k < ORDER; k++) begin : g_int
    logic [ACC_W-1:0] r_acc, w_in;
    if (k == 0) begin : g_first
      assign w_in = w_x;
    end else begin : g_next
      assign w_in = g_int[k-1].r_acc;
    end
    always_ff @(posedge clk)
      if (rst) r_acc <= '0;
      else if (en) r_acc <= r_acc + w_in;
  end
  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    logic [ACC_W-1:0] r_dly, w_in, w_out;
    if (k == 0) begin : g_first
      assign w_in = g_int[ORDER-1].r_acc;
    end else begin : g_next
      assign w_in = g_comb[k-1].w_out;
    end
    assign w_out = w_in - r_dly;
    always_ff @(posedge clk)
      if (rst) r_dly <= '0;
      else if (w_tick) r_dly <= w_in;
  end
  assign w_sh = $signed(g_comb[ORDER-1].w_out) >>> (ACC_W - OUT_W);
  always_ff @(posedge clk)
    if (rst) begin
      sample_o <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= w_tick;
      if (w_tick) sample_o <= w_sh[OUT_W-1:0];
    end
  assign w_last = r_bcnt == BW'(OUT_W - 1);
  assign w_load = valid_o && (r_state == IDLE || w_last);
  assign w_drop = valid_o && r_state == SHIFT && !w_last;
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb w_next = (w_load || (r_state == SHIFT && !w_last)) ? SHIFT : IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      r_bcnt <= '0;
      r_shreg <= '0;
      r_ovr <= 1'b0;
    end else begin
      if (w_load) begin
        r_bcnt <= '0;
        r_shreg <= sample_o;
      end else if (r_state == SHIFT) begin
        r_bcnt <= r_bcnt + BW'(1);
        r_shreg <= MSB_FIRST ? r_shreg << 1 : r_shreg >> 1;
      end
      if (w_drop) r_ovr <= 1'b1;
    end
  assign frame_sync = r_state == SHIFT;
  assign data_o = frame_sync && (MSB_FIRST ? r_shreg[OUT_W-1] : r_shreg[0]);
  assign overrun_o = r_ovr || w_drop;
endmodule

// File: tb/tb_cic_decimator_ser.sv
// tb_cic_decimator_ser: table, directed and random checks of two CIC configurations against a convolution model
module tb_cic_decimator_ser;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, data_i = 1'b0;
  logic [15:0] sa, sb;
  logic va, vb, da, db, fa, fb, oa, ob;
  always #5 clk = ~clk;
  cic_decimator_ser ua (
    .clk(clk), .rst(rst), .en(en), .data_i(data_i), .sample_o(sa), .valid_o(va),
    .data_o(da), .frame_sync(fa), .overrun_o(oa)
  );
  cic_decimator_ser #(.ORDER(5), .LOG2_R(3), .OUT_W(16), .SYNC_STAGES(2), .MSB_FIRST(1'b0)) ub (
    .clk(clk), .rst(rst), .en(en), .data_i(data_i), .sample_o(sb), .valid_o(vb),
    .data_o(db), .frame_sync(fb), .overrun_o(ob)
  );
  typedef longint lq_t[$];
  typedef struct {
    int pat;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic ov_a;
    logic ov_b;
  } vec_t;
  int errors = 0, checks = 0;
  lq_t ha, hb, xh;
  int steps = 0;
  int msync[2];
  logic [15:0] e_smp[2], f_word[2];
  bit e_val[2], f_act[2], e_ovr[2];
  int f_pos[2];
  int pn[2] = '{3, 5};
  int pl[2] = '{6, 3};
  bit pmsb[2] = '{1'b1, 1'b0};
  bit chk_on = 1'b0;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic lq_t make_h(int n, int r);
    lq_t h, t;
    h.push_back(1);
    for (int k = 0; k < n; k++) begin
      t.delete();
      for (int i = 0; i < h.size() + r - 1; i++) t.push_back(0);
      for (int i = 0; i < h.size(); i++)
        for (int j = 0; j < r; j++) t[i+j] += h[i];
      h = t;
    end
    return h;
  endfunction
  function automatic logic [15:0] model_y(int d, int s);
    longint y = 0;
    longint hv;
    int hn = (d == 0) ? ha.size() : hb.size();
    int acc = pn[d] * pl[d] + 2;
    for (int j = 0; j < hn; j++) begin
      int u = s - pn[d] - j;
      hv = (d == 0) ? ha[j] : hb[j];
      if (u >= 0) y += hv * xh[u];
    end
    y &= (longint'(1) << acc) - 1;
    if (y[acc-1]) y -= longint'(1) << acc;
    y = y >>> (acc - 16);
    return y[15:0];
  endfunction
  task automatic model_step();
    longint x;
    if (rst) begin
      msync = '{0, 0};
      xh.delete();
      steps = 0;
      for (int d = 0; d < 2; d++) begin
        e_smp[d] = '0; e_val[d] = 0; f_act[d] = 0; f_pos[d] = 0; f_word[d] = '0; e_ovr[d] = 0;
      end
    end else begin
      x = msync[1] != 0 ? 1 : -1;
      msync[1] = msync[0];
      msync[0] = int'(data_i);
      for (int d = 0; d < 2; d++) begin
        if (e_val[d] && (!f_act[d] || f_pos[d] == 15)) begin
          f_act[d] = 1; f_pos[d] = 0; f_word[d] = e_smp[d];
        end else begin
          if (e_val[d]) e_ovr[d] = 1;
          if (f_act[d]) begin
            if (f_pos[d] == 15) f_act[d] = 0;
            else f_pos[d]++;
          end
        end
        e_val[d] = 0;
      end
      if (en) begin
        xh.push_back(x);
        for (int d = 0; d < 2; d++)
          if (steps % (1 << pl[d]) == (1 << pl[d]) - 1) begin
            e_smp[d] = model_y(d, steps);
            e_val[d] = 1;
          end
        steps++;
      end
    end
  endtask
  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic [15:0] w;
      int idx;
      bit ed, eo;
      string p;
      p = d == 0 ? "a" : "b";
      w = f_word[d];
      idx = pmsb[d] ? 15 - f_pos[d] : f_pos[d];
      ed = f_act[d] && w[idx];
      eo = e_ovr[d] || (e_val[d] && f_act[d] && f_pos[d] != 15);
      check($sformatf("%s.sample", p), d == 0 ? sa : sb, e_smp[d]);
      check($sformatf("%s.valid", p), d == 0 ? va : vb, e_val[d]);
      check($sformatf("%s.frame_sync", p), d == 0 ? fa : fb, f_act[d]);
      check($sformatf("%s.data", p), d == 0 ? da : db, ed);
      check($sformatf("%s.overrun", p), d == 0 ? oa : ob, eo);
    end
  endtask
  initial forever begin
    @(posedge clk);
    model_step();
  end
  initial forever begin
    @(negedge clk);
    if (chk_on) check_all();
  end
  task automatic step(logic d);
    @(negedge clk);
    data_i = d;
  endtask
  task automatic stepp(int pat);
    step(pat == 2 ? ~data_i : pat[0]);
  endtask
  task automatic do_reset(int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic grab_a(int pat, output logic [15:0] w, output bit ok);
    int n = 0;
    ok = 0;
    w = '0;
    while (fa && n < 300) begin stepp(pat); n++; end
    while (!fa && n < 300) begin stepp(pat); n++; end
    if (n < 300) begin
      ok = 1;
      for (int k = 0; k < 16; k++) begin
        w[15-k] = da;
        stepp(pat);
      end
    end
  endtask
  vec_t tbl[3];
  initial begin
    logic [15:0] w;
    bit ok;
    int n, vcnt;
    ha = make_h(3, 64);
    hb = make_h(5, 8);
    tbl[0] = '{1, 16'h4000, 16'h4000, 1'b0, 1'b1};
    tbl[1] = '{0, 16'hC000, 16'hC000, 1'b0, 1'b1};
    tbl[2] = '{2, 16'h0000, 16'h0000, 1'b0, 1'b1};
    en = 1'b1;
    @(negedge clk);
    chk_on = 1'b1;
    check("rst.sample", sa, 0);
    check("rst.frame_sync", fa, 0);
    check("rst.overrun", ob, 0);
    for (int i = 0; i < 3; i++) begin
      do_reset(4);
      repeat (420) stepp(tbl[i].pat);
      check($sformatf("tbl%0d.sample_a", i), sa, tbl[i].exp_a);
      check($sformatf("tbl%0d.sample_b", i), sb, tbl[i].exp_b);
      grab_a(tbl[i].pat, w, ok);
      check($sformatf("tbl%0d.frame_found", i), ok, 1);
      check($sformatf("tbl%0d.frame_a", i), w, tbl[i].exp_a);
      check($sformatf("tbl%0d.overrun_a", i), oa, tbl[i].ov_a);
      check($sformatf("tbl%0d.overrun_b", i), ob, tbl[i].ov_b);
    end
    do_reset(4);
    n = 0;
    while (!fb && n < 100) begin stepp(1); n++; end
    check("lsb.frame_found", n < 100, 1);
    repeat (48) stepp(1);
    w = '0;
    for (int k = 0; k < 16; k++) begin
      w[k] = db;
      stepp(1);
    end
    check("lsb.frame_b", w, 16'h4000);
    repeat (200) stepp(1);
    en = 1'b0;
    vcnt = 0;
    repeat (100) begin
      stepp(1);
      vcnt += int'(va) + int'(vb);
    end
    check("en_low.valids", vcnt, 0);
    en = 1'b1;
    repeat (200) stepp(1);
    n = 0;
    while (!(fa && !va) && n < 100) begin stepp(1); n++; end
    while (fa && n < 200) begin stepp(1); n++; end
    while (!fa && n < 200) begin stepp(1); n++; end
    check("rst_mid.frame_found", n < 200, 1);
    repeat (4) stepp(1);
    rst = 1'b1;
    step(1'b1);
    check("rst_mid.frame_sync", fa, 0);
    check("rst_mid.data", da, 0);
    check("rst_mid.sample", sa, 0);
    check("rst_mid.overrun_b", ob, 0);
    rst = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      stepp(1);
      if (i == 63) check("restart.valid_early", va, 0);
      if (i == 64) check("restart.valid_on_time", va, 1);
    end
    do_reset(4);
    for (int b = 0; b < 20; b++) begin
      int p = $urandom_range(0, 100);
      repeat (100) begin
        en = $urandom_range(0, 9) != 0;
        step($urandom_range(0, 99) < p);
      end
    end
    en = 1'b1;
    repeat (5) stepp(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
